mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, single-outstanding memory between the core's instruction-fetch port and its load/store port. Data accesses take priority, and a streak limit guarantees fetch progress. A response timeout turns a hung memory into an error response instead of a deadlocked core. The block sits between the fetch/LSU stages and the unified instruction/data RAM.

## Interface
- STREAK_MAX, 4: consecutive data grants allowed while fetch is waiting (1..15).
- TIMEOUT, 255: maximum cycles in WAIT before an error response (1..255).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch word address (byte address, [1:0] ignored).
- if_gnt  out  1  fetch request accepted by memory (1-cycle pulse).
- if_rvalid  out  1  fetch response valid (1-cycle pulse).
- if_rdata  out  32  fetch data; valid only with if_rvalid.
- if_err  out  1  fetch timeout; qualifies if_rvalid.
- d_req  in  1  load/store request; payload held until d_gnt.
- d_we  in  1  1 = store.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables.
- d_gnt, d_rvalid, d_err  out  1 each  same meaning as the fetch port.
- d_rdata  out  32  load data; 0 for stores.
- mem_req  out  1  request to memory.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/32/32/4  payload of the selected requester.
- mem_ready  in  1  memory accepts when mem_req & mem_ready.
- mem_rvalid  in  1  response (read data or write ack), one per accepted request.
- mem_rdata  in  32  read data.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - REQ: mem_req=1, owner's payload muxed to mem_*.
  - WAIT: accepted, awaiting mem_rvalid.
- Arbitration, evaluated in IDLE and in the WAIT cycle where mem_rvalid=1:
  - Only one of d_req/if_req asserted: that requester wins.
  - Both asserted: data wins, unless streak==STREAK_MAX, then fetch wins.
  - Winner is registered as owner; next state REQ. No request: next state IDLE.
- Streak counter (4 bit):
  - Data grant with if_req=1: increments.
  - Fetch grant, or data grant with if_req=0: clears.
  - Saturates at STREAK_MAX.
- REQ:
  - On mem_ready=1: pulse owner gnt, clear timeout counter, go to WAIT.
  - Otherwise hold with the payload unchanged.
- WAIT:
  - mem_rvalid=1: owner rvalid=1, rdata=mem_rdata (stores: 0), err=0.
  - Timeout counter reaches TIMEOUT: owner rvalid=1, err=1, rdata=0; go to IDLE. Arbitration resumes in IDLE on the next cycle.
- mem_rvalid outside WAIT is ignored. The memory contract forbids responses after TIMEOUT.
- mem_* payload outputs are 0 when not in REQ.
- Non-owner port rvalid/gnt/err are always 0.

## Timing
- Reset value of all outputs is 0; state IDLE, streak 0, owner = data, timeout counter 0.
- Reset mid-transaction returns to IDLE. An in-flight mem_rvalid is dropped.
- Request raised in IDLE at cycle 0 → mem_req at cycle 1. With mem_ready=1, gnt also at cycle 1. mem_rvalid earliest at cycle 2, which gives rvalid at cycle 2 (combinational pass-through of mem_rdata).
- Back-to-back: a request pending in the response cycle gives mem_req on the very next cycle, so there is no IDLE bubble.
- Timeout: rvalid/err assert on the cycle the counter reaches TIMEOUT, i.e. TIMEOUT cycles after entering WAIT.
- Requests dropped by a requester before gnt are protocol violations. Behaviour is undefined and is not checked.

## Test plan
- Single fetch: if_req=1, addr 0x8, mem_ready=1, mem_rvalid at 2, mem_rdata 0x00a00113 → if_gnt at cycle 1, if_rvalid=1/if_rdata=0x00a00113 at cycle 2, all d_* zero.
- Contention: both requests held continuously with memory 1-cycle latency, STREAK_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I; requests back-to-back with no IDLE gap.
- Store: d_we=1, d_addr 0x100, d_wdata 0xdeadbeef, d_wstrb 0xf, mem_ready low 3 cycles → mem_* stable over 3 cycles, d_gnt on the ready cycle, d_rvalid with d_rdata=0.
- Timeout: TIMEOUT=8, no mem_rvalid → d_rvalid=1, d_err=1, d_rdata=0 exactly 8 cycles after gnt. A pending fetch is granted afterwards, and a late mem_rvalid in IDLE produces no output.
- Reset in WAIT: assert reset one cycle, then mem_rvalid arrives → no rvalid on either port, all outputs 0, a new fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses around the fetch/LSU memory arbiter:
//     fetch port  : if_req, if_addr -> if_gnt, if_rvalid, if_rdata, if_err
//     data port   : d_req, d_we, d_addr, d_wdata, d_wstrb
//                   -> d_gnt, d_rvalid, d_rdata, d_err
//     memory side : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//                   <- mem_ready, mem_rvalid, mem_rdata
//   modport slave  : the arbiter's view (requests in, memory responses in)
//   modport master : the environment's view (requesters plus memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    // load/store port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    // memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, single-outstanding memory between the instruction
//   fetch port and the load/store port. Data wins contention until it has
//   taken STREAK_MAX grants in a row while fetch waited; then fetch goes once.
//   A response that does not arrive within TIMEOUT cycles after acceptance is
//   turned into an error response so the core never deadlocks.
//
//   Parameters
//     STREAK_MAX : consecutive data grants allowed while fetch waits (1..15)
//     TIMEOUT    : cycles after acceptance before an error response (1..255)
//   Ports
//     clk   : rising-edge clock
//     reset : synchronous, active-high
//     bus   : mem_port_arbiter_if.slave (fetch port, data port, memory side)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
    // The counter holds (cycles spent in WAIT - 1), so the timeout fires on
    // the TIMEOUT-th WAIT cycle, i.e. TIMEOUT cycles after the grant.
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       owner_is_data_q, owner_is_data_d;
    logic [3:0] streak_q, streak_d;
    logic [7:0] tmo_q, tmo_d;
    logic       store_q, store_d;   // accepted access was a store

    logic in_req;
    logic in_wait;
    logic accept;
    logic resp_ok;
    logic resp_tmo;
    logic resp_any;
    logic arb_en;
    logic any_req;
    logic pick_data;

    assign in_req   = (state_q == ST_REQ);
    assign in_wait  = (state_q == ST_WAIT);
    assign accept   = in_req & bus.mem_ready;
    assign resp_ok  = in_wait & bus.mem_rvalid;
    assign resp_tmo = in_wait & ~bus.mem_rvalid & (tmo_q == TMO_LAST);
    assign resp_any = resp_ok | resp_tmo;

    // Arbitrate when idle and also in the response cycle, so a pending
    // request reaches the memory on the very next cycle. A timeout cycle
    // does not arbitrate; arbitration resumes from IDLE.
    assign arb_en    = (state_q == ST_IDLE) | resp_ok;
    assign any_req   = bus.d_req | bus.if_req;
    assign pick_data = bus.d_req & (~bus.if_req | (streak_q != STREAK_LIM));

    always_comb begin
        state_d         = state_q;
        owner_is_data_d = owner_is_data_q;
        streak_d        = streak_q;
        tmo_d           = tmo_q;
        store_d         = store_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.mem_ready) begin
                    state_d = ST_WAIT;
                    tmo_d   = 8'd0;
                    store_d = owner_is_data_q & bus.d_we;
                end
            end
            ST_WAIT: begin
                if (resp_tmo) begin
                    state_d = ST_IDLE;
                end else if (!bus.mem_rvalid) begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arb_en) begin
            if (any_req) begin
                state_d         = ST_REQ;
                owner_is_data_d = pick_data;
                // Only a data grant that made fetch wait extends the streak.
                if (pick_data && bus.if_req) begin
                    streak_d = (streak_q == STREAK_LIM) ? STREAK_LIM : streak_q + 4'd1;
                end else begin
                    streak_d = 4'd0;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            owner_is_data_q <= 1'b1;
            streak_q        <= 4'd0;
            tmo_q           <= 8'd0;
            store_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_is_data_q <= owner_is_data_d;
            streak_q        <= streak_d;
            tmo_q           <= tmo_d;
            store_q         <= store_d;
        end
    end

    // Memory payload: only driven while presenting a request. Fetch carries
    // no write payload, so its lanes stay zero.
    logic        sel_data;
    logic [31:0] wdata_w;
    logic [3:0]  wstrb_w;

    assign sel_data = in_req & owner_is_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wstrb_w[gi]        = sel_data & bus.d_wstrb[gi];
            assign wdata_w[8*gi +: 8] = sel_data ? bus.d_wdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign bus.mem_req   = in_req;
    assign bus.mem_we    = sel_data & bus.d_we;
    assign bus.mem_addr  = in_req ? (owner_is_data_q ? bus.d_addr : bus.if_addr) : 32'd0;
    assign bus.mem_wdata = wdata_w;
    assign bus.mem_wstrb = wstrb_w;

    // Requester-side handshake: only the owner ever sees gnt/rvalid/err.
    assign bus.d_gnt     = accept & owner_is_data_q;
    assign bus.if_gnt    = accept & ~owner_is_data_q;
    assign bus.d_rvalid  = resp_any & owner_is_data_q;
    assign bus.if_rvalid = resp_any & ~owner_is_data_q;
    assign bus.d_err     = resp_tmo & owner_is_data_q;
    assign bus.if_err    = resp_tmo & ~owner_is_data_q;

    // Read data passes straight through in the response cycle; a store ack
    // and an error response both return zero.
    assign bus.d_rdata   = (resp_ok & owner_is_data_q & ~store_q) ? bus.mem_rdata : 32'd0;
    assign bus.if_rdata  = (resp_ok & ~owner_is_data_q) ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios (single fetch, contention order, held store, timeout,
//   reset during WAIT) followed by randomized traffic. A transaction-level
//   reference model predicts every arbiter output each cycle. Inputs are
//   driven 1 time unit after the rising edge and outputs sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int SMAX = 4;
    localparam int TMO  = 8;

    // bit positions in the packed control snapshot
    localparam int B_REQ  = 11;
    localparam int B_WE   = 10;
    localparam int B_DGNT = 5;
    localparam int B_IGNT = 4;
    localparam int B_DRV  = 3;
    localparam int B_IRV  = 2;
    localparam int B_DERR = 1;
    localparam int B_IERR = 0;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ntx    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STREAK_MAX (SMAX),
        .TIMEOUT    (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // reference model: one transaction in flight at most
    bit t_on    = 1'b0;   // a requester has won and owns the memory
    bit t_acc   = 1'b0;   // memory accepted it, response pending
    bit t_data  = 1'b1;   // owner is the data port
    bit t_store = 1'b0;
    int t_age   = 0;      // cycles since acceptance
    int streak  = 0;      // data wins in a row while fetch waited

    logic [11:0] e_ctrl, s_ctrl;
    logic [31:0] e_addr, e_wdata, e_drdata, e_irdata;
    logic [31:0] s_addr, s_wdata, s_drdata, s_irdata;
    bit          ok_c, tmo_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic eval_model();
        e_ctrl   = '0;
        e_addr   = '0;
        e_wdata  = '0;
        e_drdata = '0;
        e_irdata = '0;
        ok_c  = t_acc && (bus.mem_rvalid === 1'b1);
        tmo_c = t_acc && (bus.mem_rvalid !== 1'b1) && (t_age == TMO);
        if (t_on && !t_acc) begin
            e_ctrl[B_REQ] = 1'b1;
            if (t_data) begin
                e_ctrl[B_WE]  = bus.d_we;
                e_ctrl[9:6]   = bus.d_wstrb;
                e_addr        = bus.d_addr;
                e_wdata       = bus.d_wdata;
            end else begin
                e_addr = bus.if_addr;
            end
            if (bus.mem_ready) e_ctrl[t_data ? B_DGNT : B_IGNT] = 1'b1;
        end
        if (ok_c || tmo_c) begin
            e_ctrl[t_data ? B_DRV : B_IRV] = 1'b1;
            if (tmo_c) e_ctrl[t_data ? B_DERR : B_IERR] = 1'b1;
            if (ok_c && t_data && !t_store) e_drdata = bus.mem_rdata;
            if (ok_c && !t_data) e_irdata = bus.mem_rdata;
        end
    endtask

    task automatic advance_model();
        bit free;
        bit gnt;
        gnt = e_ctrl[B_DGNT] | e_ctrl[B_IGNT];
        if (reset) begin
            t_on = 1'b0; t_acc = 1'b0; t_data = 1'b1; t_store = 1'b0;
            t_age = 0; streak = 0;
            return;
        end
        if (ok_c || tmo_c) begin
            ntx++;
            $display("txn %0d cycle %0d port=%s store=%0d err=%0d rdata=%h",
                     ntx, cyc, t_data ? "D" : "I", t_store, tmo_c,
                     t_data ? e_drdata : e_irdata);
        end
        free = !t_on || ok_c;
        if (gnt) begin
            t_acc   = 1'b1;
            t_age   = 1;
            t_store = t_data && bus.d_we;
        end else if (t_acc) begin
            t_age++;
        end
        if (tmo_c) begin
            t_on = 1'b0; t_acc = 1'b0;
        end else if (free) begin
            if (bus.d_req || bus.if_req) begin
                t_data = bus.d_req && (!bus.if_req || streak != SMAX);
                streak = (t_data && bus.if_req) ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
                t_on   = 1'b1;
                t_acc  = 1'b0;
            end else begin
                t_on = 1'b0; t_acc = 1'b0;
            end
        end
    endtask

    // One clock cycle: sample on the falling edge, check, update the model,
    // then return just after the next rising edge for the caller to drive.
    task automatic step();
        @(negedge clk);
        s_ctrl   = {bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.d_gnt, bus.if_gnt,
                    bus.d_rvalid, bus.if_rvalid, bus.d_err, bus.if_err};
        s_addr   = bus.mem_addr;
        s_wdata  = bus.mem_wdata;
        s_drdata = bus.d_rdata;
        s_irdata = bus.if_rdata;
        eval_model();
        chk("ctrl",      32'(s_ctrl), 32'(e_ctrl));
        chk("mem_addr",  s_addr,   e_addr);
        chk("mem_wdata", s_wdata,  e_wdata);
        chk("d_rdata",   s_drdata, e_drdata);
        chk("if_rdata",  s_irdata, e_irdata);
        advance_model();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        reset          = 1'b0;
        bus.if_req     = 1'b0;
        bus.if_addr    = 32'd0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = 32'd0;
        bus.d_wdata    = 32'd0;
        bus.d_wstrb    = 4'd0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
    endtask

    task automatic reset_dut();
        clr_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [9:0] gord;
        int         ng;
        int         first_g;
        int         last_g;
        int         lat;

        clr_inputs();
        reset = 1'b1;
        reset_dut();

        // reset state: everything quiet
        step();
        chk("rst_ctrl",  32'(s_ctrl), 32'd0);
        chk("rst_addr",  s_addr,   32'd0);
        chk("rst_rdata", s_drdata | s_irdata, 32'd0);

        // ---- single fetch ----
        bus.if_req = 1'b1; bus.if_addr = 32'h8; bus.mem_ready = 1'b1;
        step();
        chk("sf_c0_req", 32'(s_ctrl[B_REQ]), 32'd0);
        step();
        chk("sf_gnt",  32'(s_ctrl[B_IGNT]), 32'd1);
        chk("sf_addr", s_addr, 32'h8);
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00a00113;
        step();
        chk("sf_rvalid", 32'(s_ctrl[B_IRV]), 32'd1);
        chk("sf_rdata",  s_irdata, 32'h00a00113);
        chk("sf_dside",  32'({s_ctrl[B_DGNT], s_ctrl[B_DRV], s_ctrl[B_DERR]}), 32'd0);
        chk("sf_drdata", s_drdata, 32'd0);
        clr_inputs();

        // ---- contention, 1-cycle memory ----
        reset_dut();
        bus.d_req = 1'b1; bus.if_req = 1'b1; bus.mem_ready = 1'b1;
        bus.d_addr = 32'h200; bus.if_addr = 32'h1000;
        gord = '0; ng = 0; first_g = -1; last_g = -1;
        for (int c = 0; c < 24; c++) begin
            bus.mem_rvalid = t_acc;
            bus.mem_rdata  = $urandom;
            step();
            if (s_ctrl[B_DGNT] || s_ctrl[B_IGNT]) begin
                if (ng < 10) begin
                    gord = {gord[8:0], s_ctrl[B_DGNT]};
                    if (ng == 0) first_g = c;
                    if (ng == 9) last_g = c;
                end
                ng++;
            end
            if (s_ctrl[B_DGNT]) bus.d_addr = bus.d_addr + 32'd4;
            if (s_ctrl[B_IGNT]) bus.if_addr = bus.if_addr + 32'd4;
        end
        chk("ct_order", 32'(gord), 32'(10'b1111011110));
        chk("ct_span",  32'(last_g - first_g), 32'd18);
        clr_inputs();

        // ---- store with memory stalling ----
        reset_dut();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
        bus.d_wdata = 32'hdeadbeef; bus.d_wstrb = 4'hf; bus.mem_ready = 1'b0;
        step();
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("st_hold_req",   32'(s_ctrl[B_REQ]), 32'd1);
            chk("st_hold_addr",  s_addr,  32'h100);
            chk("st_hold_wdata", s_wdata, 32'hdeadbeef);
            chk("st_nognt",      32'(s_ctrl[B_DGNT]), 32'd0);
        end
        bus.mem_ready = 1'b1;
        step();
        chk("st_gnt",   32'(s_ctrl[B_DGNT]), 32'd1);
        chk("st_we",    32'(s_ctrl[B_WE]), 32'd1);
        chk("st_wstrb", 32'(s_ctrl[9:6]), 32'hf);
        clr_inputs();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        step();
        chk("st_rvalid", 32'(s_ctrl[B_DRV]), 32'd1);
        chk("st_rdata",  s_drdata, 32'd0);
        clr_inputs();

        // ---- timeout, then pending fetch, late response ignored ----
        reset_dut();
        bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.mem_ready = 1'b1;
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        step();
        chk("to_gnt", 32'(s_ctrl[B_DGNT]), 32'd1);
        bus.d_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'hffffffff;
        for (int k = 1; k < TMO; k++) begin
            step();
            chk("to_early", 32'(s_ctrl[B_DRV]), 32'd0);
        end
        step();
        chk("to_rvalid", 32'(s_ctrl[B_DRV]), 32'd1);
        chk("to_err",    32'(s_ctrl[B_DERR]), 32'd1);
        chk("to_rdata",  s_drdata, 32'd0);
        bus.mem_rvalid = 1'b1;
        step();
        chk("to_late",     32'({s_ctrl[B_DRV], s_ctrl[B_IRV], s_ctrl[B_DERR], s_ctrl[B_IERR]}), 32'd0);
        chk("to_late_req", 32'(s_ctrl[B_REQ]), 32'd0);
        bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b1;
        step();
        chk("to_fetch_gnt",  32'(s_ctrl[B_IGNT]), 32'd1);
        chk("to_fetch_addr", s_addr, 32'h80);
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0badf00d;
        step();
        chk("to_fetch_rdata", s_irdata, 32'h0badf00d);
        clr_inputs();

        // ---- reset while waiting for the response ----
        reset_dut();
        bus.if_req = 1'b1; bus.if_addr = 32'h20; bus.mem_ready = 1'b1;
        step();
        step();
        chk("rw_gnt0", 32'(s_ctrl[B_IGNT]), 32'd1);
        bus.if_req = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55aa55aa;
        step();
        chk("rw_ctrl",  32'(s_ctrl), 32'd0);
        chk("rw_rdata", s_irdata | s_drdata, 32'd0);
        bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h24;
        step();
        step();
        chk("rw_gnt1", 32'(s_ctrl[B_IGNT]), 32'd1);
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000013;
        step();
        chk("rw_rvalid", 32'(s_ctrl[B_IRV]), 32'd1);
        chk("rw_rdata1", s_irdata, 32'h00000013);
        clr_inputs();

        // ---- randomized traffic ----
        reset_dut();
        lat = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!bus.d_req || e_ctrl[B_DGNT]) begin
                bus.d_req   = ($urandom_range(0, 99) < 60);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
                bus.d_wstrb = 4'($urandom_range(0, 15));
            end
            if (!bus.if_req || e_ctrl[B_IGNT]) begin
                bus.if_req  = ($urandom_range(0, 99) < 60);
                bus.if_addr = $urandom;
            end
            // pick a latency when the model saw an acceptance; 0 means hang
            if (e_ctrl[B_DGNT] || e_ctrl[B_IGNT])
                lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TMO - 1);
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            if (t_acc) bus.mem_rvalid = (t_age == lat);
            else       bus.mem_rvalid = ($urandom_range(0, 9) == 0);
            bus.mem_rdata = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
